// File: rtl/quadra_sweep.sv
// quadra_sweep: issues an arithmetic sweep of arguments to a fixed-latency
// polynomial evaluator, pairs each returned y with its argument and streams
// the results out through a small FIFO with credit-based flow control.
module quadra_sweep #(
    parameter int unsigned X_W   = 24,
    parameter int unsigned Y_W   = 24,
    parameter int unsigned LAT   = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [X_W-1:0]   x_base,
    input  logic [X_W-1:0]   x_step,
    input  logic [15:0]      n_points,
    output logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [X_W-1:0]   res_x,
    output logic [Y_W-1:0]   res_y,
    output logic             res_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned CW    = $clog2(DEPTH + LAT + 2) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic           issued;
        logic           last;
        logic [X_W-1:0] x;
    } tag_t;

    typedef struct packed {
        logic           last;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } res_t;

    state_t             state, state_n;
    logic [X_W-1:0]     arg, step;
    logic [15:0]        remaining;
    logic               issued_q, last_q;
    tag_t               pipe [LAT];
    res_t               mem  [DEPTH];
    res_t               head_c;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_count, fifo_count_n;
    logic [CW-1:0]      inflight;
    logic               issue_c, last_c, push_c, pop_c;
    tag_t               exit_c;

    // The x register plus issued_q/last_q form the first tag stage; pipe adds LAT more.
    assign exit_c  = pipe[LAT-1];
    assign push_c  = exit_c.issued;
    assign pop_c   = res_valid && res_ready;
    assign head_c  = mem[rd_ptr];
    assign res_x   = head_c.x;
    assign res_y   = head_c.y;
    assign res_last = res_valid && head_c.last;

    // Credit check: outstanding tags plus stored results must leave room for one more.
    always_comb begin
        issue_c      = 1'b0;
        last_c       = 1'b0;
        fifo_count_n = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
        if (state == RUN && remaining != 16'd0 &&
            (CW'(fifo_count) + inflight) < CW'(DEPTH)) begin
            issue_c = 1'b1;
            last_c  = (remaining == 16'd1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (n_points == 16'd0) ? DONE : RUN;
            RUN:     if (remaining == 16'd0) state_n = DRAIN;
            DRAIN:   if (inflight == '0 && fifo_count == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state == DONE);
        end
    end

    // Argument generator and first tag stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arg       <= '0;
            step      <= '0;
            remaining <= '0;
            x         <= '0;
            issued_q  <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                arg       <= x_base;
                step      <= x_step;
                remaining <= n_points;
            end else if (issue_c) begin
                arg       <= arg + step;
                remaining <= remaining - 16'd1;
            end
            if (issue_c) x <= arg;
            issued_q <= issue_c;
            last_q   <= last_c;
        end
    end

    // Tag pipeline aligned with the evaluator latency, plus in-flight count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
            inflight <= '0;
        end else begin
            pipe[0] <= '{issued: issued_q, last: last_q, x: x};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            inflight <= inflight + CW'(issue_c) - CW'(push_c);
        end
    end

    // Result FIFO; writes never meet a full FIFO thanks to the credit check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            res_valid  <= 1'b0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= '{last: exit_c.last, x: exit_c.x, y: y};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count_n;
            res_valid  <= (fifo_count_n != '0);
        end
    end

endmodule

// File: tb/tb_quadra_sweep.sv
// Bench for quadra_sweep: behavioural evaluator, result scoreboard, directed
// scenarios followed by a long sweep with random backpressure.
module tb_quadra_sweep;

    localparam int unsigned X_W   = 24;
    localparam int unsigned Y_W   = 24;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [X_W-1:0] x_base, x_step;
    logic [15:0]    n_points;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           res_valid, res_ready;
    logic [X_W-1:0] res_x;
    logic [Y_W-1:0] res_y;
    logic           res_last, busy, done;

    int   checks = 0;
    int   errors = 0;
    int   n_acc  = 0;
    bit   credit_viol = 1'b0;
    exp_t exp_q[$];
    logic [X_W-1:0] ev [LAT];

    quadra_sweep #(.X_W(X_W), .Y_W(Y_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .x_base(x_base), .x_step(x_step),
        .n_points(n_points), .x(x), .y(y), .res_valid(res_valid),
        .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
        .res_last(res_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [Y_W-1:0] poly(input logic [X_W-1:0] a);
        logic [63:0] t;
        t = 64'(a);
        return Y_W'(64'd3 * t * t + 64'd5 * t + 64'd7);
    endfunction

    // Evaluator model: y is poly(x) exactly LAT cycles after x is presented.
    always @(posedge clk) begin
        ev[0] <= x;
        for (int i = 1; i < LAT; i++) ev[i] <= ev[i-1];
    end
    assign y = poly(ev[LAT-1]);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard on accepted results and credit invariant.
    always @(negedge clk) begin
        if (!rst) begin
            if (32'(dut.fifo_count) + 32'(dut.inflight) > DEPTH) credit_viol = 1'b1;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL spurious_result observed res_x=%0h expected none", res_x);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_x", 64'(res_x), 64'(e.x));
                    chk("res_y", 64'(res_y), 64'(e.y));
                    chk("res_last", 64'(res_last), 64'(e.last));
                    n_acc++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle and enqueue the expected results of the sweep.
    task automatic do_sweep(input logic [X_W-1:0] b, input logic [X_W-1:0] s, input int n);
        x_base   = b;
        x_step   = s;
        n_points = 16'(n);
        start    = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.x    = X_W'(64'(b) + 64'(i) * 64'(s));
            e.y    = poly(e.x);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (rnd) begin
                res_ready = 1'($urandom_range(0, 1));
                start     = (k == 10);
            end
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int acc0;
        int k;
        logic [X_W-1:0] b, s, xf;

        rst = 1'b1; start = 1'b0; x_base = '0; x_step = '0; n_points = '0; res_ready = 1'b1;
        tick(); tick();
        chk("rst_x", 64'(x), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_last", 64'(res_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // Basic three-point sweep: issue order, latency, done pulse.
        acc0 = n_acc;
        do_sweep(24'h000100, 24'h000001, 3);
        chk("s1_x_before_issue", 64'(x), 64'd0);
        tick();
        chk("s1_x0", 64'(x), 64'h100);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) chk("s1_x1", 64'(x), 64'h101);
            if (i == 2) chk("s1_x2", 64'(x), 64'h102);
            if (res_valid) begin
                k = i;
                break;
            end
        end
        chk("s1_first_valid_latency", 64'(k), 64'(LAT + 1));
        wait_done("s1", 50, 1'b0);
        chk("s1_count", 64'(n_acc - acc0), 64'd3);
        tick();
        chk("s1_done_width", 64'(done), 64'd0);

        // Empty sweep.
        acc0 = n_acc;
        do_sweep(24'h123456, 24'h000010, 0);
        chk("s0_busy_c1", 64'(busy), 64'd1);
        chk("s0_done_c1", 64'(done), 64'd0);
        tick();
        chk("s0_busy_c2", 64'(busy), 64'd0);
        chk("s0_done_c2", 64'(done), 64'd1);
        tick();
        chk("s0_done_c3", 64'(done), 64'd0);
        chk("s0_no_results", 64'(n_acc - acc0), 64'd0);

        // Argument wrap-around.
        acc0 = n_acc;
        do_sweep(24'hFFFFFE, 24'h000001, 4);
        wait_done("wrap", 60, 1'b0);
        chk("wrap_count", 64'(n_acc - acc0), 64'd4);

        // Full backpressure: exactly DEPTH issues, then x frozen.
        acc0 = n_acc;
        b = X_W'($urandom);
        s = X_W'($urandom);
        res_ready = 1'b0;
        do_sweep(b, s, 10);
        for (int i = 0; i < 20; i++) tick();
        xf = x;
        chk("bp_x_last_issued", 64'(x), 64'(X_W'(64'(b) + 64'(DEPTH - 1) * 64'(s))));
        chk("bp_fifo_full", 64'(dut.fifo_count), 64'(DEPTH));
        chk("bp_res_valid", 64'(res_valid), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("bp_x_frozen", 64'(x), 64'(xf));
        res_ready = 1'b1;
        wait_done("bp", 100, 1'b0);
        chk("bp_count", 64'(n_acc - acc0), 64'd10);

        // Reset mid-sweep abandons it.
        do_sweep(24'h000500, 24'h000003, 10);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_x", 64'(x), 64'd0);
        chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_res_last", 64'(res_last), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_rst_no_stale", 64'(n_acc - acc0), 64'd0);
        do_sweep(24'h000777, 24'h000002, 2);
        wait_done("post_rst", 60, 1'b0);
        chk("post_rst_count", 64'(n_acc - acc0), 64'd2);

        // Long sweep with random backpressure and an ignored start while busy.
        acc0 = n_acc;
        credit_viol = 1'b0;
        do_sweep(X_W'($urandom), X_W'($urandom), 200);
        wait_done("rand", 5000, 1'b1);
        res_ready = 1'b1;
        chk("rand_count", 64'(n_acc - acc0), 64'd200);
        chk("rand_credit", 64'(credit_viol), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("rand_idle_after", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
